// File: rtl/axi_pkg.sv
// axi_pkg: FSM states, AXI constants and requester indices shared by axi_arbiter.
package axi_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_AR, ST_R, ST_AWW, ST_B} state_t;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic       REQ_M0         = 1'b0;
  localparam logic       REQ_M1         = 1'b1;
endpackage

// File: rtl/axi_arb_grant.sv
// axi_arb_grant: 2-way grant choice; round-robin when AXI_ARBITER_RR_EN is defined,
// otherwise fixed priority with m1 winning simultaneous requests.
module axi_arb_grant
  import axi_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_take,
  output logic o_win
);
`ifdef AXI_ARBITER_RR_EN
  logic r_last;
  assign o_win = (i_req0 && i_req1) ? ~r_last : i_req1;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_last <= REQ_M1;
    else if (i_take) r_last <= o_win;
  end
`else
  logic w_unused;
  assign w_unused = ^{clock, reset, i_take, i_req0};
  assign o_win = i_req1 ? REQ_M1 : REQ_M0;
`endif
endmodule

// File: rtl/axi_arbiter.sv
// axi_arbiter: two requesters (m0 IFU, m1 LSU) sharing one AXI4 master, one transaction at a time.
// Define AXI_ARBITER_RR_EN for round-robin arbitration; default is fixed m1 priority.
module axi_arbiter
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_req_valid,
  output logic              m0_req_ready,
  input  logic              m0_req_wen,
  input  logic [ADDR_W-1:0] m0_req_addr,
  input  logic [DATA_W-1:0] m0_req_wdata,
  input  logic [3:0]        m0_req_wstrb,
  input  logic [2:0]        m0_req_size,
  output logic              m0_rsp_valid,
  output logic [DATA_W-1:0] m0_rsp_rdata,
  output logic              m0_rsp_err,
  input  logic              m1_req_valid,
  output logic              m1_req_ready,
  input  logic              m1_req_wen,
  input  logic [ADDR_W-1:0] m1_req_addr,
  input  logic [DATA_W-1:0] m1_req_wdata,
  input  logic [3:0]        m1_req_wstrb,
  input  logic [2:0]        m1_req_size,
  output logic              m1_rsp_valid,
  output logic [DATA_W-1:0] m1_rsp_rdata,
  output logic              m1_rsp_err,
  output logic              io_master_awvalid,
  input  logic              io_master_awready,
  output logic [3:0]        io_master_awid,
  output logic [ADDR_W-1:0] io_master_awaddr,
  output logic [7:0]        io_master_awlen,
  output logic [2:0]        io_master_awsize,
  output logic [1:0]        io_master_awburst,
  output logic              io_master_wvalid,
  input  logic              io_master_wready,
  output logic [DATA_W-1:0] io_master_wdata,
  output logic [3:0]        io_master_wstrb,
  output logic              io_master_wlast,
  input  logic              io_master_bvalid,
  output logic              io_master_bready,
  input  logic [3:0]        io_master_bid,
  input  logic [1:0]        io_master_bresp,
  output logic              io_master_arvalid,
  input  logic              io_master_arready,
  output logic [3:0]        io_master_arid,
  output logic [ADDR_W-1:0] io_master_araddr,
  output logic [7:0]        io_master_arlen,
  output logic [2:0]        io_master_arsize,
  output logic [1:0]        io_master_arburst,
  input  logic              io_master_rvalid,
  output logic              io_master_rready,
  input  logic [3:0]        io_master_rid,
  input  logic [DATA_W-1:0] io_master_rdata,
  input  logic [1:0]        io_master_rresp,
  input  logic              io_master_rlast,
  output logic              grant_id
);
  state_t            r_state, w_next;
  logic              r_grant, r_aw_done, r_w_done, r_rsp_err;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_rsp_rdata;
  logic [3:0]        r_wstrb;
  logic [2:0]        r_size;
  logic [1:0]        r_rsp_valid;
  logic              w_any, w_win, w_take, w_wen;
  logic              w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs, w_aw_fin, w_w_fin;
  logic              w_unused;

  assign w_unused = ^{io_master_bid, io_master_rid, io_master_rlast};
  assign w_any    = m0_req_valid | m1_req_valid;
  // Gating with reset keeps ready low while reset is held, even with requests pending.
  assign w_take   = reset && r_state == ST_IDLE && w_any;
  assign w_wen    = w_win ? m1_req_wen : m0_req_wen;

  axi_arb_grant u_grant (
    .clock  (clock),
    .reset  (reset),
    .i_req0 (m0_req_valid),
    .i_req1 (m1_req_valid),
    .i_take (w_take),
    .o_win  (w_win)
  );

  assign m0_req_ready      = w_take && w_win == REQ_M0;
  assign m1_req_ready      = w_take && w_win == REQ_M1;
  assign io_master_arvalid = r_state == ST_AR;
  assign io_master_rready  = r_state == ST_R;
  assign io_master_awvalid = r_state == ST_AWW && !r_aw_done;
  assign io_master_wvalid  = r_state == ST_AWW && !r_w_done;
  assign io_master_wlast   = io_master_wvalid;
  assign io_master_bready  = r_state == ST_B;
  assign io_master_arid    = '0;
  assign io_master_arlen   = '0;
  assign io_master_arburst = AXI_BURST_INCR;
  assign io_master_araddr  = r_addr;
  assign io_master_arsize  = r_size;
  assign io_master_awid    = '0;
  assign io_master_awlen   = '0;
  assign io_master_awburst = AXI_BURST_INCR;
  assign io_master_awaddr  = r_addr;
  assign io_master_awsize  = r_size;
  assign io_master_wdata   = r_wdata;
  assign io_master_wstrb   = r_wstrb;
  assign grant_id          = r_grant;

  assign w_ar_hs  = io_master_arvalid && io_master_arready;
  assign w_r_hs   = io_master_rready && io_master_rvalid;
  assign w_aw_hs  = io_master_awvalid && io_master_awready;
  assign w_w_hs   = io_master_wvalid && io_master_wready;
  assign w_b_hs   = io_master_bready && io_master_bvalid;
  assign w_aw_fin = r_aw_done || w_aw_hs;
  assign w_w_fin  = r_w_done || w_w_hs;

  assign m0_rsp_valid = r_rsp_valid[0];
  assign m0_rsp_rdata = r_rsp_valid[0] ? r_rsp_rdata : '0;
  assign m0_rsp_err   = r_rsp_valid[0] && r_rsp_err;
  assign m1_rsp_valid = r_rsp_valid[1];
  assign m1_rsp_rdata = r_rsp_valid[1] ? r_rsp_rdata : '0;
  assign m1_rsp_err   = r_rsp_valid[1] && r_rsp_err;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: w_next = w_any ? (w_wen ? ST_AWW : ST_AR) : ST_IDLE;
      ST_AR:   w_next = w_ar_hs ? ST_R : ST_AR;
      ST_R:    w_next = w_r_hs ? ST_IDLE : ST_R;
      ST_AWW:  w_next = (w_aw_fin && w_w_fin) ? ST_B : ST_AWW;
      ST_B:    w_next = w_b_hs ? ST_IDLE : ST_B;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_grant     <= REQ_M0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_size      <= '0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_rsp_valid <= '0;
      if (w_take) begin
        r_grant   <= w_win;
        r_addr    <= w_win ? m1_req_addr : m0_req_addr;
        r_wdata   <= w_win ? m1_req_wdata : m0_req_wdata;
        r_wstrb   <= w_win ? m1_req_wstrb : m0_req_wstrb;
        r_size    <= w_win ? m1_req_size : m0_req_size;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs) r_w_done <= 1'b1;
      if (w_r_hs || w_b_hs) begin
        r_rsp_valid <= r_grant ? 2'b10 : 2'b01;
        r_rsp_rdata <= w_r_hs ? io_master_rdata : '0;
        r_rsp_err   <= (w_r_hs ? io_master_rresp : io_master_bresp) != AXI_RESP_OKAY;
      end
    end
  end
endmodule

// File: tb/tb_axi_arbiter.sv
// tb_axi_arbiter: directed scenarios plus randomized traffic, checked every cycle against a
// transaction-level model of the arbiter (grant rule, channel contents, response pulses).
module tb_axi_arbiter;
  logic        clock = 1'b0, reset = 1'b0;
  logic        m0_req_valid, m0_req_ready, m0_req_wen, m1_req_valid, m1_req_ready, m1_req_wen;
  logic [31:0] m0_req_addr, m0_req_wdata, m1_req_addr, m1_req_wdata;
  logic [3:0]  m0_req_wstrb, m1_req_wstrb;
  logic [2:0]  m0_req_size, m1_req_size;
  logic        m0_rsp_valid, m0_rsp_err, m1_rsp_valid, m1_rsp_err;
  logic [31:0] m0_rsp_rdata, m1_rsp_rdata;
  logic        io_master_awvalid, io_master_awready, io_master_wvalid, io_master_wready, io_master_wlast;
  logic        io_master_bvalid, io_master_bready, io_master_arvalid, io_master_arready;
  logic        io_master_rvalid, io_master_rready, io_master_rlast, grant_id;
  logic [3:0]  io_master_awid, io_master_wstrb, io_master_bid, io_master_arid, io_master_rid;
  logic [31:0] io_master_awaddr, io_master_wdata, io_master_araddr, io_master_rdata;
  logic [7:0]  io_master_awlen, io_master_arlen;
  logic [2:0]  io_master_awsize, io_master_arsize;
  logic [1:0]  io_master_awburst, io_master_arburst, io_master_bresp, io_master_rresp;

  axi_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_wen(m0_req_wen),
    .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata), .m0_req_wstrb(m0_req_wstrb),
    .m0_req_size(m0_req_size), .m0_rsp_valid(m0_rsp_valid), .m0_rsp_rdata(m0_rsp_rdata),
    .m0_rsp_err(m0_rsp_err),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_wen(m1_req_wen),
    .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata), .m1_req_wstrb(m1_req_wstrb),
    .m1_req_size(m1_req_size), .m1_rsp_valid(m1_rsp_valid), .m1_rsp_rdata(m1_rsp_rdata),
    .m1_rsp_err(m1_rsp_err),
    .io_master_awvalid(io_master_awvalid), .io_master_awready(io_master_awready),
    .io_master_awid(io_master_awid), .io_master_awaddr(io_master_awaddr),
    .io_master_awlen(io_master_awlen), .io_master_awsize(io_master_awsize),
    .io_master_awburst(io_master_awburst),
    .io_master_wvalid(io_master_wvalid), .io_master_wready(io_master_wready),
    .io_master_wdata(io_master_wdata), .io_master_wstrb(io_master_wstrb),
    .io_master_wlast(io_master_wlast),
    .io_master_bvalid(io_master_bvalid), .io_master_bready(io_master_bready),
    .io_master_bid(io_master_bid), .io_master_bresp(io_master_bresp),
    .io_master_arvalid(io_master_arvalid), .io_master_arready(io_master_arready),
    .io_master_arid(io_master_arid), .io_master_araddr(io_master_araddr),
    .io_master_arlen(io_master_arlen), .io_master_arsize(io_master_arsize),
    .io_master_arburst(io_master_arburst),
    .io_master_rvalid(io_master_rvalid), .io_master_rready(io_master_rready),
    .io_master_rid(io_master_rid), .io_master_rdata(io_master_rdata),
    .io_master_rresp(io_master_rresp), .io_master_rlast(io_master_rlast),
    .grant_id(grant_id)
  );

  int checks = 0, errors = 0, cyc = 0, bh = 0;
  int gl_m[$], gl_c[$], rl_m[$], rl_c[$];
  logic [31:0] rl_d[$];
  logic        rl_e[$];
  bit          busy, own, last = 1'b1, ar_s, aw_s, w_s, pend, pm, pe, t_wen, win, e0, e1;
  logic [31:0] t_addr, t_wdata, pd;
  logic [3:0]  t_strb;
  logic [2:0]  t_size;

  initial forever #5 clock = ~clock;
  initial forever begin
    @(posedge clock);
    cyc++;
  end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  // Reference model: one transaction at a time; flags record which AXI handshakes are done.
  initial forever begin
    @(negedge clock);
    if (!reset) begin
      chk("reset_outputs", {m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid, m0_rsp_err,
          m1_rsp_err, io_master_arvalid, io_master_rready, io_master_awvalid, io_master_wvalid,
          io_master_bready, grant_id}, 0);
      chk("reset_addr", {io_master_araddr, io_master_awaddr}, 0);
      busy = 0; last = 1; pend = 0;
    end else begin
`ifdef AXI_ARBITER_RR_EN
      win = (m0_req_valid && m1_req_valid) ? !last : m1_req_valid;
`else
      win = m1_req_valid;
`endif
      e0 = !busy && m0_req_valid && !win;
      e1 = !busy && m1_req_valid && win;
      chk("m0_req_ready", m0_req_ready, e0);
      chk("m1_req_ready", m1_req_ready, e1);
      if (m0_req_ready) begin gl_m.push_back(0); gl_c.push_back(cyc); end
      if (m1_req_ready) begin gl_m.push_back(1); gl_c.push_back(cyc); end
      chk("m0_rsp_valid", m0_rsp_valid, pend && !pm);
      chk("m1_rsp_valid", m1_rsp_valid, pend && pm);
      if (pend) chk("rsp_data", pm ? {m1_rsp_err, m1_rsp_rdata} : {m0_rsp_err, m0_rsp_rdata}, {pe, pd});
      if (m0_rsp_valid) begin rl_m.push_back(0); rl_d.push_back(m0_rsp_rdata); rl_e.push_back(m0_rsp_err); rl_c.push_back(cyc); end
      if (m1_rsp_valid) begin rl_m.push_back(1); rl_d.push_back(m1_rsp_rdata); rl_e.push_back(m1_rsp_err); rl_c.push_back(cyc); end
      if (busy) chk("grant_id", grant_id, own);
      chk("arvalid", io_master_arvalid, busy && !t_wen && !ar_s);
      if (busy && !t_wen && !ar_s)
        chk("ar_fields", {io_master_araddr, io_master_arid, io_master_arlen, io_master_arsize, io_master_arburst},
            {t_addr, 4'd0, 8'd0, t_size, 2'b01});
      chk("rready", io_master_rready, busy && !t_wen && ar_s);
      chk("awvalid", io_master_awvalid, busy && t_wen && !aw_s);
      if (busy && t_wen && !aw_s)
        chk("aw_fields", {io_master_awaddr, io_master_awid, io_master_awlen, io_master_awsize, io_master_awburst},
            {t_addr, 4'd0, 8'd0, t_size, 2'b01});
      chk("wvalid_wlast", {io_master_wvalid, io_master_wlast}, {2{busy && t_wen && !w_s}});
      if (busy && t_wen && !w_s) chk("w_fields", {io_master_wstrb, io_master_wdata}, {t_strb, t_wdata});
      chk("bready", io_master_bready, busy && t_wen && aw_s && w_s);
      if (io_master_bready && io_master_bvalid) bh++;
      pend = 0;
      if (busy && !t_wen) begin
        if (ar_s && io_master_rvalid) begin
          pend = 1; pm = own; pd = io_master_rdata; pe = io_master_rresp != 0; busy = 0;
        end
        if (io_master_arready) ar_s = 1;
      end else if (busy) begin
        if (aw_s && w_s && io_master_bvalid) begin
          pend = 1; pm = own; pd = 0; pe = io_master_bresp != 0; busy = 0;
        end
        if (io_master_awready) aw_s = 1;
        if (io_master_wready) w_s = 1;
      end else if (m0_req_valid || m1_req_valid) begin
        busy = 1; own = win; last = win; ar_s = 0; aw_s = 0; w_s = 0;
        t_wen = win ? m1_req_wen : m0_req_wen;
        t_addr = win ? m1_req_addr : m0_req_addr;
        t_wdata = win ? m1_req_wdata : m0_req_wdata;
        t_strb = win ? m1_req_wstrb : m0_req_wstrb;
        t_size = win ? m1_req_size : m0_req_size;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    gl_m.delete(); gl_c.delete(); rl_m.delete(); rl_c.delete(); rl_d.delete(); rl_e.delete();
  endtask

  task automatic idle();
    m0_req_valid = 0; m1_req_valid = 0; m0_req_wen = 0; m1_req_wen = 0;
    io_master_arready = 0; io_master_rvalid = 0; io_master_awready = 0; io_master_wready = 0;
    io_master_bvalid = 0; io_master_rresp = 0; io_master_bresp = 0;
  endtask

  task automatic wait_rsp(input int n);
    for (int i = 0; i < 40 && rl_m.size() < n; i++) tick();
    chk("rsp_count", rl_m.size(), n);
  endtask

  task automatic rst_pulse();
    reset = 0;
    tick();
    reset = 1;
  endtask

  int c0, b0;
  bit r0, r1;
  initial begin
    idle();
    m0_req_addr = 0; m0_req_wdata = 0; m0_req_wstrb = 0; m0_req_size = 0;
    m1_req_addr = 0; m1_req_wdata = 0; m1_req_wstrb = 0; m1_req_size = 0;
    io_master_bid = 0; io_master_rid = 0; io_master_rdata = 0; io_master_rlast = 1;
    m0_req_valid = 1; m1_req_valid = 1;
    #3;
    chk("por_ready", {m0_req_ready, m1_req_ready, io_master_arvalid, grant_id}, 0);
    m0_req_valid = 0; m1_req_valid = 0;
    tick(); tick();
    reset = 1;
    tick();

    // single read, zero-wait slave
    clr();
    m0_req_valid = 1; m0_req_addr = 32'h8000_0000; m0_req_size = 3'd2;
    io_master_arready = 1; io_master_rvalid = 1; io_master_rdata = 32'h0000_0413; c0 = cyc;
    tick(); m0_req_valid = 0;
    wait_rsp(1);
    if (rl_m.size() >= 1) begin
      chk("t1_rsp", {rl_m[0][0], rl_e[0], rl_d[0]}, {1'b0, 1'b0, 32'h413});
      chk("t1_latency", rl_c[0] - c0, 3);
    end
    idle(); tick();

    // write with W accepted two cycles before AW
    clr(); b0 = bh;
    m1_req_valid = 1; m1_req_wen = 1; m1_req_addr = 32'hA000_03F8; m1_req_wdata = 32'h41;
    m1_req_wstrb = 4'b0001; m1_req_size = 3'd0; c0 = cyc;
    tick(); m1_req_valid = 0; io_master_wready = 1;
    chk("t2_wdata", {io_master_wvalid, io_master_wstrb, io_master_wdata}, {1'b1, 4'b0001, 32'h41});
    tick(); io_master_wready = 0;
    chk("t2_aw_pending", {io_master_awvalid, io_master_wvalid, io_master_awaddr}, {2'b10, 32'hA000_03F8});
    tick(); io_master_awready = 1;
    tick(); io_master_awready = 0; io_master_bvalid = 1;
    tick(); io_master_bvalid = 0;
    wait_rsp(1);
    chk("t2_b_handshakes", bh - b0, 1);
    if (rl_m.size() >= 1) begin
      chk("t2_rsp", {rl_m[0][0], rl_e[0], rl_d[0]}, {1'b1, 1'b0, 32'h0});
      chk("t2_latency", rl_c[0] - c0, 5);
    end
    idle(); tick();

    // simultaneous continuous reads
    rst_pulse(); clr();
    m0_req_valid = 1; m0_req_addr = 32'h100; m1_req_valid = 1; m1_req_addr = 32'h200;
    io_master_arready = 1; io_master_rvalid = 1;
    for (int i = 0; i < 40 && gl_m.size() < 4; i++) tick();
    m0_req_valid = 0; m1_req_valid = 0;
    chk("t3_grants", gl_m.size(), 4);
    wait_rsp(4);
    for (int i = 0; i < 4 && i < gl_m.size(); i++) begin
`ifdef AXI_ARBITER_RR_EN
      chk("t3_order", gl_m[i], i % 2);
`else
      chk("t3_order", gl_m[i], 1);
`endif
      if (i > 0) chk("t3_spacing", gl_c[i] - gl_c[i-1], 3);
    end
    idle(); tick();

    // error response on m1, then a clean read for m0
    clr();
    m1_req_valid = 1; m1_req_addr = 32'h40; io_master_arready = 1; io_master_rvalid = 1;
    io_master_rdata = 32'hDEAD_BEEF; io_master_rresp = 2'b10;
    tick(); m1_req_valid = 0;
    wait_rsp(1);
    io_master_rresp = 0; io_master_rdata = 32'h1234; m0_req_valid = 1; m0_req_addr = 32'h44;
    tick(); m0_req_valid = 0;
    wait_rsp(2);
    if (rl_m.size() >= 2) begin
      chk("t4_m1_err", {rl_m[0][0], rl_e[0], rl_d[0]}, {1'b1, 1'b1, 32'hDEAD_BEEF});
      chk("t4_m0_ok", {rl_m[1][0], rl_e[1], rl_d[1]}, {1'b0, 1'b0, 32'h1234});
    end
    idle(); tick();

    // reset asserted while waiting in R
    clr();
    m0_req_valid = 1; m0_req_addr = 32'h1000; io_master_arready = 1;
    tick(); m0_req_valid = 0;
    tick();
    chk("t5_in_r", io_master_rready, 1);
    #2 reset = 0; m1_req_valid = 1; m1_req_addr = 32'h2000;
    #1 chk("t5_async_zero", {m0_req_ready, m1_req_ready, io_master_arvalid, io_master_rready,
        io_master_awvalid, io_master_wvalid, io_master_bready, grant_id, io_master_araddr}, 0);
    tick(); io_master_rvalid = 1; io_master_rdata = 32'h55;
    tick(); reset = 1; c0 = cyc;
    tick(); m1_req_valid = 0;
    wait_rsp(1);
    if (rl_m.size() >= 1) begin
      chk("t5_next_rsp", {rl_m[0][0], rl_d[0]}, {1'b1, 32'h55});
      chk("t5_latency", rl_c[0] - c0, 3);
    end
    idle(); tick();

    // AR stall with requester address churning
    clr();
    m1_req_valid = 1; m1_req_addr = 32'h3000_0010; m1_req_size = 3'd2;
    tick(); m1_req_valid = 0;
    for (int i = 0; i < 10; i++) begin
      m1_req_addr = $urandom;
      #1 chk("t6_stable", {io_master_arvalid, io_master_araddr}, {1'b1, 32'h3000_0010});
      tick();
    end
    io_master_arready = 1; io_master_rvalid = 1; io_master_rdata = 32'h77;
    wait_rsp(1);
    if (rl_m.size() >= 1) chk("t6_rsp", {rl_m[0][0], rl_d[0]}, {1'b1, 32'h77});
    idle(); tick();

    // randomized traffic, including requesters withdrawing before ready
    for (int k = 0; k < 3000; k++) begin
      @(negedge clock);
      r0 = m0_req_ready; r1 = m1_req_ready;
      tick();
      if (r0 || (m0_req_valid && $urandom_range(15) == 0)) m0_req_valid = 0;
      if (!m0_req_valid && $urandom_range(3) == 0) begin
        m0_req_valid = 1; m0_req_wen = 1'($urandom_range(1)); m0_req_addr = $urandom;
        m0_req_wdata = $urandom; m0_req_wstrb = 4'($urandom); m0_req_size = 3'($urandom_range(2));
      end
      if (r1 || (m1_req_valid && $urandom_range(15) == 0)) m1_req_valid = 0;
      if (!m1_req_valid && $urandom_range(3) == 0) begin
        m1_req_valid = 1; m1_req_wen = 1'($urandom_range(1)); m1_req_addr = $urandom;
        m1_req_wdata = $urandom; m1_req_wstrb = 4'($urandom); m1_req_size = 3'($urandom_range(2));
      end
      io_master_arready = $urandom_range(2) != 0; io_master_awready = $urandom_range(2) != 0;
      io_master_wready = $urandom_range(2) != 0; io_master_rvalid = $urandom_range(2) != 0;
      io_master_bvalid = $urandom_range(2) != 0; io_master_rdata = $urandom;
      io_master_rresp = 2'($urandom); io_master_bresp = 2'($urandom);
      io_master_rid = 4'($urandom); io_master_bid = 4'($urandom);
    end
    idle(); tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_arbiter.md
AXI_ARBITER -- requirements
Module: axi_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have requester ports for m0 (IFU) and m1 (LSU), one set each, prefixed m0_ or m1_:
- req_valid, input, 1 bit.
- req_ready, output, 1 bit.
- req_wen, input, 1 bit: 1 = write, 0 = read.
- req_addr, input, ADDR_W bits.
- req_wdata, input, DATA_W bits.
- req_wstrb, input, 4 bits.
- req_size, input, 3 bits.
REQ-006 SHALL have response ports per requester, prefixed m0_ or m1_:
- rsp_valid, output, 1 bit.
- rsp_rdata, output, DATA_W bits.
- rsp_err, output, 1 bit.
REQ-007 SHALL have io_master_* AXI4 channels AW, W, B, AR, R with the usual directions and widths (id 4, len 8, size 3, burst 2, resp 2, wstrb 4).
REQ-008 SHALL have output grant_id, 1 bit: the requester that owns the bus; valid when not IDLE.

Function
REQ-009 SHALL implement FSM states IDLE, AR, R, AWW, B.
REQ-010 SHALL arbitrate in IDLE when any req_valid is high:
- Latch grant_id, addr, wdata, wstrb, size and wen.
- Pulse req_ready of the winner for exactly that cycle.
- Next state AR if wen=0, else AWW.
REQ-011 SHALL hold AR until arvalid&arready, then go to R.
REQ-012 SHALL hold R until rvalid&rready, then go to IDLE:
- Pulse rsp_valid of the owner for one cycle with rsp_rdata=rdata and rsp_err=(rresp!=0).
REQ-013 SHALL assert awvalid and wvalid together in AWW:
- Drop each independently after its own handshake; either may complete first or both in the same cycle.
- Go to B when both have completed.
REQ-014 SHALL hold B until bvalid&bready, then go to IDLE:
- Pulse rsp_valid of the owner with rsp_err=(bresp!=0) and rsp_rdata=0.
REQ-015 SHALL drive rready only in R and bready only in B.
REQ-016 SHALL tie AXI fields as follows:
- id, len = 0; burst = 2'b01; wlast = wvalid.
- arsize/awsize = latched size.
REQ-017 SHALL keep channel outputs stable from the latched copy while valid is high, independent of requester inputs.
REQ-018 SHALL hold a granted transaction until its response: no preemption and no outstanding transactions beyond one.
REQ-019 SHALL take back-to-back grants through IDLE, for a minimum of 3 cycles per read (IDLE, AR, R) at zero-wait slave.
REQ-020 SHALL ignore a requester that drops req_valid before req_ready; nothing is latched for it.
REQ-021 SHALL treat a response with id mismatch as a normal response, since id is fixed at 0.

Reset
REQ-022 SHALL, while reset is low, force state=IDLE, all valid/ready/rsp outputs=0, grant_id=0, latched registers=0, and last-grant=m1.
REQ-023 SHALL abandon any in-flight transaction when reset asserts mid-transaction; no response is pulsed to the requester.

Configuration
REQ-024 SHALL, with macro AXI_ARBITER_RR_EN defined, use round-robin: on simultaneous requests the requester not granted last wins, and last-grant updates on each grant.
REQ-025 SHALL, without AXI_ARBITER_RR_EN, use fixed priority with m1 (LSU) always winning simultaneous requests; last-grant register is absent.

Structure
REQ-026 SHALL place the FSM state enum, AXI_BURST_INCR, AXI_RESP_OKAY and requester index constants in shared package axi_pkg.
REQ-027 SHALL implement the 2-way grant decision (RR/fixed) as sub-module axi_arb_grant: combinational choice plus last-grant register.

Verification
REQ-028 SHALL cover a single read: m0 read 0x8000_0000, slave arready=1 and rvalid one cycle later with rdata 0x0000_0413 -> m0_rsp_valid one cycle, rdata 0x413, err 0, 3 cycles from request.
REQ-029 SHALL cover a write with W before AW: m1 write 0xA000_03F8 data 0x41 wstrb 0001; wready=1 at cycle 1, awready at cycle 3 -> one bready handshake, m1_rsp_valid, err 0.
REQ-030 SHALL cover simultaneous requests: both requesting read continuously for 4 grants -> RR order m0, m1, m0, m1; without the macro m1 on all 4.
REQ-031 SHALL cover an error response: rresp=2'b10 on an m1 read -> m1_rsp_err=1, and m0 is unaffected.
REQ-032 SHALL cover reset mid-flight: reset low during R -> all outputs 0 asynchronously, no rsp_valid, and the next request starts in IDLE.
REQ-033 SHALL cover stall stability: arready held 0 for 10 cycles while req_addr changes -> araddr constant and arvalid high throughout.
